// File: rtl/run_seq_pkg.sv
// Shared types, default widths and the state-to-output decode for the run sequencer.
package run_seq_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_MAX_CYCLES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } run_state_t;

    typedef struct packed {
        logic host_gnt;
        logic core_sel;
        logic core_run;
        logic core_rst;
        logic done;
        logic timeout;
    } run_outs_t;

    localparam run_outs_t OUTS_IDLE = '{host_gnt: 1'b1, core_sel: 1'b0, core_run: 1'b0,
                                        core_rst: 1'b0, done: 1'b0, timeout: 1'b0};

    function automatic run_outs_t decode_outputs(input run_state_t s);
        run_outs_t o;
        o = OUTS_IDLE;
        case (s)
            ST_IDLE:  o = OUTS_IDLE;
            ST_START: begin o.host_gnt = 1'b0; o.core_rst = 1'b1; end
            ST_RUN:   begin o.host_gnt = 1'b0; o.core_sel = 1'b1; o.core_run = 1'b1; end
            ST_DRAIN: begin o.host_gnt = 1'b0; o.core_sel = 1'b1; end
            ST_DONE:  begin o.done = 1'b1; end
            ST_FAULT: begin o.done = 1'b1; o.timeout = 1'b1; end
            default:  o = OUTS_IDLE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating RUN-cycle counter with synchronous clear and watchdog limit compare.
module run_cycle_counter
    import run_seq_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_CYCLES - 1);
    localparam logic             WDOG_ON  = (MAX_CYCLES != 0);

    logic [CNT_W-1:0] count_r;

    // Counter register: clear wins over enable, increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && (count_r != ALL_ONES)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign at_limit = WDOG_ON && (count_r == LIMIT);

endmodule

// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: host/core data-memory arbitration, core reset
// pulse, run enable, program-done detection and cycle-budget watchdog.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              program_done,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_gnt,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_rst,
    output logic              core_run,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    run_state_t state_r;
    run_state_t state_s;
    run_outs_t  outs_r;
    logic       at_limit_s;

    run_cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_counter (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (state_r == ST_START),
        .en       (state_r == ST_RUN),
        .count    (cycle_count),
        .at_limit (at_limit_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; program_done takes priority over the watchdog on the same edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (req) state_s = ST_START; else state_s = ST_IDLE;
            ST_START: state_s = ST_RUN;
            ST_RUN: begin
                if (program_done) begin
                    state_s = ST_DRAIN;
                end else if (at_limit_s) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: state_s = ST_DONE;
            ST_DONE:  if (!req) state_s = ST_IDLE; else state_s = ST_DONE;
            ST_FAULT: if (!req) state_s = ST_IDLE; else state_s = ST_FAULT;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output flops track the decode of the state being entered, so they always equal
    // the decode of state_r without a combinational path from the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outs_r <= OUTS_IDLE;
        end else begin
            outs_r <= decode_outputs(state_s);
        end
    end

    assign host_gnt = outs_r.host_gnt;
    assign core_run = outs_r.core_run;
    assign core_rst = outs_r.core_rst;
    assign done     = outs_r.done;
    assign timeout  = outs_r.timeout;

    // Grant-qualified write enables make dropped writes silent; neither side stalls.
    assign mem_addr   = outs_r.core_sel ? core_addr  : host_addr;
    assign mem_wdata  = outs_r.core_sel ? core_wdata : host_wdata;
    assign mem_wr_en  = (outs_r.host_gnt & host_wr_en) | (outs_r.core_run & core_wr_en);
    assign host_rdata = mem_rdata;
    assign core_rdata = mem_rdata;

endmodule
